// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: N_MASTER requesters share one slave, ownership held per CYC.
// Optional slave watchdog with ABORT state enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int unsigned N_MASTER       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_MASTER-1:0]    m_cyc_i,
  input  logic [N_MASTER-1:0]    m_stb_i,
  input  logic [N_MASTER-1:0]    m_we_i,
  input  logic [32*N_MASTER-1:0] m_adr_i,
  input  logic [32*N_MASTER-1:0] m_dat_i,
  input  logic [4*N_MASTER-1:0]  m_sel_i,
  output logic [31:0]            m_dat_o,
  output logic [N_MASTER-1:0]    m_ack_o,
  output logic [N_MASTER-1:0]    m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  input  logic [31:0]            s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [N_MASTER-1:0]    gnt_o
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned PTR_W = $clog2(N_MASTER);

  if (N_MASTER < 2 || N_MASTER > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("wb_rr_arbiter: unsupported N_MASTER or TIMEOUT_CYCLES");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_ABORT = 2'd2} state_t;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_stall;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1} state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]     r_idx, w_idx_nxt;
  logic [N_MASTER-1:0]  r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]     w_pick;
  logic                 w_found;
  logic [PTR_W-1:0]     w_idx_inc;
  logic                 w_own_cyc;
  logic [AW-1:0]        w_adr [N_MASTER];
  logic [DW-1:0]        w_dat [N_MASTER];
  logic [SW-1:0]        w_sel [N_MASTER];

  // Unpack flattened master buses so the owner can be selected by index
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      w_adr[i] = m_adr_i[i*AW +: AW];
      w_dat[i] = m_dat_i[i*DW +: DW];
      w_sel[i] = m_sel_i[i*SW +: SW];
    end
  end

  // First requester at or after r_ptr, wrapping explicitly at N_MASTER
  always_comb begin
    logic [PTR_W:0] w_j;
    w_pick  = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      w_j = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_j >= (PTR_W+1)'(N_MASTER)) w_j = w_j - (PTR_W+1)'(N_MASTER);
      if (!w_found && m_cyc_i[w_j[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_j[PTR_W-1:0];
      end
    end
  end

  assign w_idx_inc = (r_idx == PTR_W'(N_MASTER - 1)) ? '0 : r_idx + PTR_W'(1);
  assign w_own_cyc = m_cyc_i[r_idx];
  assign m_dat_o   = s_dat_i;
  assign gnt_o     = r_gnt;

  // Next-state, pointer update and owner mux onto the slave
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = r_gnt;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
`ifdef WB_ARB_TIMEOUT_EN
    w_cnt_nxt   = '0;
    w_stall     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_idx_nxt   = w_pick;
          w_gnt_nxt   = N_MASTER'(1) << w_pick;
        end
      end
      ST_OWN: begin
        s_cyc_o = w_own_cyc;
        s_stb_o = m_stb_i[r_idx] & w_own_cyc;
        s_we_o  = m_we_i[r_idx];
        s_adr_o = w_adr[r_idx];
        s_dat_o = w_dat[r_idx];
        s_sel_o = w_sel[r_idx];
        // A slave response coinciding with reset is dropped
        if (!rst_i) begin
          m_ack_o[r_idx] = s_ack_i;
          m_err_o[r_idx] = s_err_i;
        end
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_idx_inc;
          w_gnt_nxt   = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else begin
          w_stall = s_stb_o & ~s_ack_i & ~s_err_i;
          if (w_stall) begin
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              m_err_o[r_idx] = ~rst_i;
              w_state_nxt    = ST_ABORT;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_idx_inc;
          w_gnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt   <= w_gnt_nxt;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (3 masters, watchdog limit 8 when WB_ARB_TIMEOUT_EN).
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [95:0] m_adr, m_dat;
  logic [11:0] m_sel;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack, m_err, gnt;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N_MASTER(3), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m_cyc = 3'b111;
    rst   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++;
      if (gnt !== 3'b000 || s_cyc !== 1'b0 || s_adr !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: gnt=%b s_cyc=%b s_adr=%h want 000/0/0", c, gnt, s_cyc, s_adr);
      end
    end
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (gnt !== 3'b001 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b s_cyc=%b want 001/1", gnt, s_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    tick();
    s_ack = 1'b1;
    rst   = 1'b1;
    settle();
    checks++;
    if (m_ack !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ack: m_ack=%b want 000", m_ack);
    end
    tick();
    s_ack = 1'b0;
    settle();
    checks++;
    if (s_cyc !== 1'b0 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_drop: s_cyc=%b gnt=%b want 0/000", s_cyc, gnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
    m_adr[63:32] = 32'h10; m_dat[63:32] = 32'hDEADBEEF; m_sel[7:4] = 4'hF;
    tick();
    settle();
    checks++;
    if (gnt !== 3'b010 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1 ||
        s_adr !== 32'h10 || s_dat_o !== 32'hDEADBEEF || s_sel !== 4'hF || m_ack !== 3'b000) begin
      errors++;
      $display("FAIL wr_request: gnt=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h ack=%b want 010/1/1/1/10/deadbeef/f/000",
               gnt, s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, m_ack);
    end
    s_ack = 1'b1;
    settle();
    checks++;
    if (m_ack !== 3'b010) begin
      errors++;
      $display("FAIL wr_ack: m_ack=%b want 010", m_ack);
    end
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    settle();
    checks++;
    if (m_ack !== 3'b000 || s_cyc !== 1'b0 || gnt !== 3'b010) begin
      errors++;
      $display("FAIL wr_drop: m_ack=%b s_cyc=%b gnt=%b want 000/0/010", m_ack, s_cyc, gnt);
    end
    tick();
    settle();
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL wr_release: gnt=%b want 000", gnt);
    end
  endtask

  task automatic test_read_err();
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_adr[31:0] = 32'h20;
    tick();
    s_dat_i = 32'h12345678; s_ack = 1'b1;
    settle();
    checks++;
    if (s_adr !== 32'h20 || s_we !== 1'b0 || m_ack !== 3'b001 || m_dat_o !== 32'h12345678) begin
      errors++;
      $display("FAIL rd_return: adr=%h we=%b ack=%b dat=%h want 20/0/001/12345678", s_adr, s_we, m_ack, m_dat_o);
    end
    tick();
    s_ack = 1'b0; s_err = 1'b1;
    settle();
    checks++;
    if (m_err !== 3'b001 || m_ack !== 3'b000) begin
      errors++;
      $display("FAIL rd_err: m_err=%b m_ack=%b want 001/000", m_err, m_ack);
    end
    tick();
    s_err = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
    settle();
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL rd_release: gnt=%b want 000", gnt);
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    m_cyc = 3'b100; m_stb = 3'b100; m_adr[95:64] = 32'h200;
    tick();
    m_cyc = 3'b101; m_stb = 3'b101; m_adr[31:0] = 32'h300;
    for (int a = 0; a < 4; a++) begin
      s_ack = 1'b1;
      settle();
      checks++;
      if (gnt !== 3'b100 || s_adr !== 32'h200 || m_ack !== 3'b100) begin
        errors++;
        $display("FAIL burst_acc%0d: gnt=%b adr=%h ack=%b want 100/200/100", a, gnt, s_adr, m_ack);
      end
      tick();
      s_ack = 1'b0;
      settle();
      checks++;
      if (gnt !== 3'b100 || s_adr !== 32'h200 || m_ack !== 3'b000) begin
        errors++;
        $display("FAIL burst_wait%0d: gnt=%b adr=%h ack=%b want 100/200/000", a, gnt, s_adr, m_ack);
      end
      tick();
    end
    m_cyc = 3'b001; m_stb = 3'b001;
    settle();
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 3'b100) begin
      errors++;
      $display("FAIL burst_drop: s_cyc=%b s_stb=%b gnt=%b want 0/0/100", s_cyc, s_stb, gnt);
    end
    tick();
    settle();
    checks++;
    if (gnt !== 3'b000 || s_stb !== 1'b0) begin
      errors++;
      $display("FAIL burst_gap: gnt=%b s_stb=%b want 000/0", gnt, s_stb);
    end
    tick();
    settle();
    checks++;
    if (gnt !== 3'b001 || s_stb !== 1'b1 || s_adr !== 32'h300) begin
      errors++;
      $display("FAIL burst_next: gnt=%b s_stb=%b adr=%h want 001/1/300", gnt, s_stb, s_adr);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_oh;
    do_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    tick();
    for (int r = 0; r < 6; r++) begin
      exp_oh = 3'b001 << (r % 3);
      settle();
      checks++;
      if (gnt !== exp_oh) begin
        errors++;
        $display("FAIL fair_grant%0d: gnt=%b want %b", r, gnt, exp_oh);
      end
      s_ack = 1'b1;
      for (int a = 0; a < 2; a++) begin
        settle();
        checks++;
        if (m_ack !== exp_oh) begin
          errors++;
          $display("FAIL fair_ack%0d_%0d: m_ack=%b want %b", r, a, m_ack, exp_oh);
        end
        tick();
      end
      s_ack = 1'b0;
      m_cyc = m_cyc & ~exp_oh;
      m_stb = m_stb & ~exp_oh;
      tick();
      m_cyc = 3'b111; m_stb = 3'b111;
      settle();
      checks++;
      if (gnt !== 3'b000) begin
        errors++;
        $display("FAIL fair_gap%0d: gnt=%b want 000", r, gnt);
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m_cyc = 3'b110; m_stb = 3'b110;
    tick();
    for (int c = 1; c <= 7; c++) begin
      settle();
      checks++;
      if (m_err !== 3'b000 || s_cyc !== 1'b1) begin
        errors++;
        $display("FAIL to_stall%0d: m_err=%b s_cyc=%b want 000/1", c, m_err, s_cyc);
      end
      tick();
    end
    settle();
    checks++;
    if (m_err !== 3'b010 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL to_err: m_err=%b s_cyc=%b want 010/1", m_err, s_cyc);
    end
    tick();
    settle();
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_err !== 3'b000 || gnt !== 3'b010) begin
      errors++;
      $display("FAIL to_abort: s_cyc=%b s_stb=%b m_err=%b gnt=%b want 0/0/000/010", s_cyc, s_stb, m_err, gnt);
    end
    tick();
    m_cyc = 3'b100; m_stb = 3'b100;
    tick();
    settle();
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL to_idle: gnt=%b want 000", gnt);
    end
    tick();
    settle();
    checks++;
    if (gnt !== 3'b100 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL to_next: gnt=%b s_cyc=%b want 100/1", gnt, s_cyc);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_reset_mid();
    test_single_write();
    test_read_err();
    test_locked_burst();
    test_fairness();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
